bcd_subtractor_4digit_seq: RTL and testbench

Digit-serial, multi-digit packed-BCD subtractor computing |a − b| with a sign flag, one BCD digit per clock, LSD first.
- Pass 1 computes a + nines(b) + 1 (ten's-complement subtraction).
- If that pass ends without a carry, the result is negative. Pass 2 re-complements it to give the magnitude.
- Companion to the combinational BCD adder chain; uses a single shared one-digit BCD adder datapath.
- Start/busy/done handshake for use by a sequential calculator controller.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_subtractor_4digit_seq_if.sv | 29 ++
 rtl/bcd_adder_1digit.sv | 21 ++
 rtl/bcd_subtractor_4digit_seq.sv | 185 ++++++++++++++++++
 tb/tb_bcd_subtractor_4digit_seq.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types, constants and digit helpers for the BCD
//                subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int NDIGITS_DEFAULT = 4;

    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_NINE - d;
    endfunction

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= BCD_NINE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_subtractor_4digit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_subtractor_4digit_seq_if
//  Description : Start/busy/done handshake and operand/result bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_subtractor_4digit_seq_if #(
    parameter int NDIGITS = 4
);
    logic                   start;
    logic [4*NDIGITS-1:0]   a;
    logic [4*NDIGITS-1:0]   b;
    logic                   busy;
    logic                   done;
    logic [4*NDIGITS-1:0]   diff;
    logic                   neg;
    logic                   invalid;

    modport master (
        output start, a, b,
        input  busy, done, diff, neg, invalid
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, neg, invalid
    );
endinterface
`default_nettype wire

// File: rtl/bcd_adder_1digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_adder_1digit
//  Description : Single-digit BCD adder, sum = a + b + cin with decimal carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_adder_1digit (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    input  wire logic       cin,
    output logic      [3:0] sum,
    output logic            cout
);
    logic [4:0] w_bin;

    assign w_bin = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign cout  = (w_bin > 5'd9);
    // Adding 6 modulo 16 is the same as subtracting 10 for sums 10..19.
    assign sum   = cout ? (w_bin[3:0] + 4'd6) : w_bin[3:0];
endmodule
`default_nettype wire

// File: rtl/bcd_subtractor_4digit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_subtractor_4digit_seq
//  Description : Digit-serial packed-BCD |a-b| with sign, LSD first, using one
//                shared BCD digit adder (ten's complement, optional re-complement).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_subtractor_4digit_seq
    import bcd_pkg::*;
#(
    parameter int NDIGITS = NDIGITS_DEFAULT
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    bcd_subtractor_4digit_seq_if.slave   bus
);
    localparam int              KW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int              W      = 4 * NDIGITS;
    localparam logic [KW-1:0]   c_LAST = KW'(NDIGITS - 1);

    state_t          r_state;
    state_t          w_next;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic [W-1:0]    w_res_upd;
    logic [W-1:0]    r_diff;
    logic [KW-1:0]   r_k;
    logic            r_c;
    logic            r_neg;
    logic            r_inv;

    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [3:0]      w_r_dig;
    logic [3:0]      w_op_x;
    logic [3:0]      w_op_y;
    logic [3:0]      w_sum;
    logic            w_cout;
    logic            w_last;
    logic            w_in_invalid;

    assign w_last = (r_k == c_LAST);

    // Digit k of each stored word, and the working result with digit k replaced.
    always_comb begin
        w_a_dig   = 4'd0;
        w_b_dig   = 4'd0;
        w_r_dig   = 4'd0;
        w_res_upd = r_res;
        for (int i = 0; i < NDIGITS; i++) begin
            if (r_k == KW'(i)) begin
                w_a_dig              = r_a[4*i +: 4];
                w_b_dig              = r_b[4*i +: 4];
                w_r_dig              = r_res[4*i +: 4];
                w_res_upd[4*i +: 4]  = w_sum;
            end
        end
    end

    always_comb begin
        w_in_invalid = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!is_bcd(bus.a[4*i +: 4]) || !is_bcd(bus.b[4*i +: 4])) begin
                w_in_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        w_op_x = w_a_dig;
        w_op_y = nines_comp(w_b_dig);
        if (r_state == NEG) begin
            w_op_x = nines_comp(w_r_dig);
            w_op_y = 4'd0;
        end
    end

    bcd_adder_1digit u_adder (
        .a    (w_op_x),
        .b    (w_op_y),
        .cin  (r_c),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = w_in_invalid ? DONE : SUB;
                end
            end
            SUB: begin
                if (w_last) begin
                    w_next = w_cout ? DONE : NEG;
                end
            end
            NEG: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_k    <= '0;
            r_c    <= 1'b0;
            r_diff <= '0;
            r_neg  <= 1'b0;
            r_inv  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_res <= '0;
                        r_k   <= '0;
                        r_c   <= 1'b1;
                        if (w_in_invalid) begin
                            r_diff <= '0;
                            r_neg  <= 1'b0;
                            r_inv  <= 1'b1;
                        end
                    end
                end
                SUB: begin
                    r_res <= w_res_upd;
                    if (w_last) begin
                        if (w_cout) begin
                            r_diff <= w_res_upd;
                            r_neg  <= 1'b0;
                            r_inv  <= 1'b0;
                        end else begin
                            // No carry out means a < b: re-complement in place.
                            r_k <= '0;
                            r_c <= 1'b1;
                        end
                    end else begin
                        r_k <= r_k + KW'(1);
                        r_c <= w_cout;
                    end
                end
                NEG: begin
                    r_res <= w_res_upd;
                    if (w_last) begin
                        r_diff <= w_res_upd;
                        r_neg  <= 1'b1;
                        r_inv  <= 1'b0;
                    end else begin
                        r_k <= r_k + KW'(1);
                        r_c <= w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.diff    = r_diff;
    assign bus.neg     = r_neg;
    assign bus.invalid = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_bcd_subtractor_4digit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_subtractor_4digit_seq
//  Description : Directed, table-driven bench for the digit-serial BCD subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_subtractor_4digit_seq;

    localparam int NDIGITS = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        neg;
        logic        inv;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    bcd_subtractor_4digit_seq_if #(.NDIGITS(NDIGITS)) bus ();

    bcd_subtractor_4digit_seq #(.NDIGITS(NDIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        int  cyc;
        int  busy_low;
        bit  seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = v.a;
        bus.b     = v.b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc       = 0;
        busy_low  = 0;
        seen      = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            cyc = i;
            if (!bus.busy) busy_low++;
            if (bus.done) seen = 1'b1;
        end
        check({name, " latency"}, seen ? cyc : 0, v.lat);
        check({name, " busy"}, busy_low, 0);
        check({name, " diff"}, {16'h0, bus.diff}, {16'h0, v.diff});
        check({name, " neg"}, {31'h0, bus.neg}, {31'h0, v.neg});
        check({name, " invalid"}, {31'h0, bus.invalid}, {31'h0, v.inv});
        @(negedge clk);
        check({name, " done_pulse"}, {30'h0, bus.done, bus.busy}, 32'h0);
    endtask

    vec_t vecs[9];

    initial begin
        int dones;
        int done_cyc;

        vecs[0] = '{a: 16'h5321, b: 16'h1234, diff: 16'h4087, neg: 1'b0, inv: 1'b0, lat: 5};
        vecs[1] = '{a: 16'h1234, b: 16'h5321, diff: 16'h4087, neg: 1'b1, inv: 1'b0, lat: 9};
        vecs[2] = '{a: 16'h4567, b: 16'h4567, diff: 16'h0000, neg: 1'b0, inv: 1'b0, lat: 5};
        vecs[3] = '{a: 16'h0000, b: 16'h9999, diff: 16'h9999, neg: 1'b1, inv: 1'b0, lat: 9};
        vecs[4] = '{a: 16'h9999, b: 16'h0000, diff: 16'h9999, neg: 1'b0, inv: 1'b0, lat: 5};
        vecs[5] = '{a: 16'h12A4, b: 16'h0001, diff: 16'h0000, neg: 1'b0, inv: 1'b1, lat: 1};
        vecs[6] = '{a: 16'h0010, b: 16'h0001, diff: 16'h0009, neg: 1'b0, inv: 1'b0, lat: 5};
        vecs[7] = '{a: 16'h1000, b: 16'h0001, diff: 16'h0999, neg: 1'b0, inv: 1'b0, lat: 5};
        vecs[8] = '{a: 16'h0001, b: 16'h1000, diff: 16'h0999, neg: 1'b1, inv: 1'b0, lat: 9};

        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset outputs", {11'h0, bus.busy, bus.done, bus.diff, bus.neg, bus.invalid}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Start pulses while busy and in the DONE cycle; operands change after capture.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h0500;
        bus.b     = 16'h0123;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'h9999;
        bus.b     = 16'h1111;
        dones     = 0;
        done_cyc  = 0;
        for (int i = 1; i <= 40 && dones == 0; i++) begin
            @(negedge clk);
            if (i == 2) begin
                bus.start = 1'b1;
                bus.a     = 16'h0001;
                bus.b     = 16'h0002;
            end
            if (i == 3) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                done_cyc  = i;
                bus.start = 1'b1;
            end
        end
        check("ignore latency", done_cyc, 5);
        check("ignore diff", {16'h0, bus.diff}, 32'h0377);
        check("ignore neg", {31'h0, bus.neg}, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        check("ignore done-cycle start", {30'h0, bus.busy, bus.done}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("ignore single done", dones, 1);
        check("ignore diff held", {16'h0, bus.diff}, 32'h0377);

        // Reset in the middle of a negative operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h5321;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midop reset outputs", {11'h0, bus.busy, bus.done, bus.diff, bus.neg, bus.invalid}, 32'h0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("midop reset no done", dones, 0);
        run_op("after reset", vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
